// File: rtl/eeg_frame_packer.sv
// Packs eight 24-bit AD channel words into a 28-byte frame: A5 5A seq, payload, checksum.
// First byte one cycle after the stroke edge; out_valid/out_ready stalls hold the byte and index.
`timescale 1ns/1ps
module eeg_frame_packer #(
  parameter logic [7:0] HDR0   = 8'hA5,
  parameter logic [7:0] HDR1   = 8'h5A,
  parameter bit         CHK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pdata_stroke,
  input  logic [23:0] data_ch1,
  input  logic [23:0] data_ch2,
  input  logic [23:0] data_ch3,
  input  logic [23:0] data_ch4,
  input  logic [23:0] data_ch5,
  input  logic [23:0] data_ch6,
  input  logic [23:0] data_ch7,
  input  logic [23:0] data_ch8,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state;
  logic         stroke_q;
  logic [191:0] shadow;
  logic [7:0]   seq;
  logic [7:0]   sum;
  logic [4:0]   idx;

  logic         stroke_evt;
  logic         accept;
  logic         last;
  logic [4:0]   nidx;
  logic [4:0]   pidx;
  logic [7:0]   sum_nxt;
  logic [7:0]   next_byte;
  logic [191:0] sh_shift;
  logic [191:0] snap;

  assign stroke_evt = pdata_stroke & ~stroke_q;
  assign accept     = out_valid & out_ready;
  assign last       = (idx == 5'd27);
  assign nidx       = idx + 5'd1;
  assign pidx       = nidx - 5'd3;
  assign snap       = {data_ch1, data_ch2, data_ch3, data_ch4,
                       data_ch5, data_ch6, data_ch7, data_ch8};

  // ch1[23:16] sits at the top of the shadow, so payload byte p is at the top after a shift of 8p.
  assign sh_shift   = shadow << {pidx, 3'b000};

  always_comb begin
    sum_nxt = sum;
    if (idx >= 5'd2 && idx <= 5'd26)
      sum_nxt = sum + out_data;
    case (nidx)
      5'd1:    next_byte = HDR1;
      5'd2:    next_byte = seq;
      5'd27:   next_byte = CHK_EN ? (~sum_nxt + 8'd1) : 8'h00;
      default: next_byte = sh_shift[191:184];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      stroke_q  <= 1'b0;
      shadow    <= '0;
      seq       <= 8'h00;
      sum       <= 8'h00;
      idx       <= 5'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= 8'h00;
    end else begin
      stroke_q <= pdata_stroke;
      case (state)
        IDLE: begin
          if (stroke_evt) begin
            shadow    <= snap;
            seq       <= frame_cnt;
            sum       <= 8'h00;
            idx       <= 5'd0;
            out_data  <= HDR0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (last) begin
              frame_cnt <= frame_cnt + 8'd1;
              idx       <= 5'd0;
              // A stroke landing on the final accept chains straight into the next frame.
              if (stroke_evt) begin
                shadow   <= snap;
                seq      <= frame_cnt + 8'd1;
                sum      <= 8'h00;
                out_data <= HDR0;
              end else begin
                out_data  <= 8'h00;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
              end
            end else begin
              idx      <= nidx;
              out_data <= next_byte;
              sum      <= sum_nxt;
            end
          end
          if (stroke_evt && !(accept && last))
            overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeg_frame_packer.sv
// Directed bench for eeg_frame_packer; a byte-level scoreboard checks every accepted byte.
`timescale 1ns/1ps
module tb_eeg_frame_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pdata_stroke;
  logic [23:0] ch [8];
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overrun;
  logic [7:0]  frame_cnt;

  always #50 clk = ~clk;

  eeg_frame_packer dut (
    .clk(clk), .reset(reset), .pdata_stroke(pdata_stroke),
    .data_ch1(ch[0]), .data_ch2(ch[1]), .data_ch3(ch[2]), .data_ch4(ch[3]),
    .data_ch5(ch[4]), .data_ch6(ch[5]), .data_ch7(ch[6]), .data_ch8(ch[7]),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  int         checks = 0;
  int         errors = 0;
  int         acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_fc;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_dat = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame built from the channel words at the moment the stroke is driven.
  task automatic push_frame(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sm;
    sm = s;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(s);
    for (int i = 0; i < 8; i++) begin
      for (int k = 2; k >= 0; k--) begin
        b = ch[i][8*k +: 8];
        sm = sm + b;
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(8'h00 - sm);
  endtask

  task automatic start_frame();
    pdata_stroke = 1'b1;
    push_frame(exp_fc);
    exp_fc = exp_fc + 8'd1;
    tick();
    pdata_stroke = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((out_valid || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(tag, (n < 200), 1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && stall_pend)
        check("stall_hold", out_data, stall_dat);
      stall_pend = out_valid && !out_ready;
      stall_dat  = out_data;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0)
          check("extra_byte_q", exp_q.size(), 1);
        else
          check("byte", out_data, exp_q.pop_front());
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int n;
    reset = 1'b0;
    pdata_stroke = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ch[i] = 24'h0;
    exp_fc = 8'h00;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_data", out_data, 0);
    reset = 1'b1;

    // Single frame, all channels 000001: checksum F8.
    repeat (6) tick();
    for (int i = 0; i < 8; i++) ch[i] = 24'h000001;
    start_frame();
    check("sf_valid_rise", out_valid, 1);
    check("sf_busy", busy, 1);
    check("sf_hdr0", out_data, 8'hA5);
    repeat (27) tick();
    check("sf_valid_last", out_valid, 1);
    check("sf_chk_byte", out_data, 8'hF8);
    tick();
    check("sf_valid_end", out_valid, 0);
    check("sf_busy_end", busy, 0);
    check("sf_frame_cnt", frame_cnt, 1);
    check("sf_queue_empty", exp_q.size(), 0);

    // Backpressure with random ready.
    ch[0] = 24'h123456;
    for (int i = 1; i < 8; i++) ch[i] = 24'h100000 * i + 24'h0A0B0C;
    a0 = acc_cnt;
    out_ready = 1'b0;
    start_frame();
    n = 0;
    while ((out_valid || exp_q.size() != 0) && n < 600) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("bp_done", (n < 600), 1);
    check("bp_count", acc_cnt - a0, 28);
    check("bp_frame_cnt", frame_cnt, exp_fc);

    // Back-to-back: stroke on the cycle byte 27 is accepted.
    for (int i = 0; i < 8; i++) ch[i] = 24'h010203 * (i + 1);
    start_frame();
    repeat (27) tick();
    for (int i = 0; i < 8; i++) ch[i] = 24'hC0FFEE ^ (24'h111111 * i);
    start_frame();
    check("b2b_valid", out_valid, 1);
    check("b2b_hdr0", out_data, 8'hA5);
    check("b2b_overrun", overrun, 0);
    wait_done("b2b_done");
    check("b2b_overrun_end", overrun, 0);
    check("b2b_frame_cnt", frame_cnt, exp_fc);

    // Overrun: stroke with new ch1 while idx=10.
    for (int i = 0; i < 8; i++) ch[i] = 24'hABCDEF;
    start_frame();
    repeat (10) tick();
    ch[0] = 24'hFFFFFF;
    pdata_stroke = 1'b1;
    check("ovr_before", overrun, 0);
    tick();
    pdata_stroke = 1'b0;
    check("ovr_set", overrun, 1);
    wait_done("ovr_done");
    repeat (5) tick();
    check("ovr_no_second", out_valid, 0);
    check("ovr_sticky", overrun, 1);
    check("ovr_frame_cnt", frame_cnt, exp_fc);

    // Reset mid-frame at idx=15.
    for (int i = 0; i < 8; i++) ch[i] = 24'h5A5A5A + i;
    start_frame();
    repeat (15) tick();
    reset = 1'b0;
    exp_q.delete();
    exp_fc = 8'h00;
    tick();
    check("mr_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_frame_cnt", frame_cnt, 0);
    check("mr_overrun", overrun, 0);
    check("mr_data", out_data, 0);
    reset = 1'b1;
    repeat (3) tick();
    check("mr_quiet", out_valid, 0);
    start_frame();
    wait_done("mr_clean_done");
    check("mr_frame_cnt_after", frame_cnt, 1);

    // Wrap: 256 more frames makes 257 since reset; seq runs to FF then 00.
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 8; i++) ch[i] = 24'($urandom);
      repeat (2) tick();
      start_frame();
      wait_done("wrap_done");
      check("wrap_frame_cnt", frame_cnt, exp_fc);
    end
    check("wrap_final_cnt", frame_cnt, 8'h01);
    check("wrap_overrun", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeg_frame_packer.md
Name: eeg_frame_packer

Overview:
- Sits directly downstream of the 8-channel serial-to-parallel AD stage, in the 10 MHz clk domain.
- On each sample stroke it snapshots the eight 24-bit channel words.
- It serialises them into a 28-byte framed packet (header, sequence number, payload, checksum) for the USB FIFO writer.
- The output is a byte stream with a valid/ready handshake, so the USB side can apply backpressure.

Parameters:
- HDR0, 8'hA5, first header byte.
- HDR1, 8'h5A, second header byte.
- CHK_EN, 1, 1 = emit checksum in byte 27; 0 = byte 27 is 8'h00.

Ports:
- clk  in  1  10 MHz system clock; the only clock in this block.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- pdata_stroke  in  1  sample-ready strobe from the AD stage, synchronous to clk.
- data_ch1 .. data_ch8  in  24 each  channel words; stable while pdata_stroke is high.
- out_data  out  8  current packet byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte on a cycle where out_valid && out_ready.
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a stroke was dropped.
- frame_cnt  out  8  number of completed frames, modulo 256.

Behaviour:
- Reset (reset==0 at posedge clk), from any state, including mid-frame:
  - state = IDLE; out_valid=0, out_data=0, busy=0, overrun=0, frame_cnt=0, byte index=0.
  - A partial frame is abandoned; no byte of it appears after reset is released.
- Stroke detection: a stroke event is a 0->1 transition of pdata_stroke, registered against its previous-cycle value. A multi-cycle high counts as one event. The edge register resets to 0.
- States: IDLE, SEND.
- IDLE:
  - On a stroke event in cycle N: latch all 192 channel bits and latch seq=frame_cnt into shadow registers, and clear the checksum accumulator.
  - Cycle N+1: state=SEND, busy=1, out_valid=1, out_data=HDR0, idx=0.
- SEND, byte order by idx:
  - 0: HDR0
  - 1: HDR1
  - 2: seq
  - 3..26: ch1[23:16], ch1[15:8], ch1[7:0], ch2[23:16] ... ch8[7:0] (each channel MSB first, ch1 first)
  - 27: checksum
- Handshake:
  - idx advances only on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and idx hold unchanged.
  - out_valid never drops mid-frame.
- Checksum:
  - sum = 8-bit wraparound sum of bytes idx 2..26, accumulated as each is accepted.
  - Byte 27 = (~sum)+1, so that bytes 2..27 sum to 8'h00.
  - If CHK_EN=0, byte 27 = 8'h00.
- Frame end, when byte 27 is accepted:
  - frame_cnt increments, wrapping 8'hFF -> 8'h00.
  - If no stroke event occurs that cycle: next cycle state=IDLE, out_valid=0, busy=0, out_data=0.
  - If a stroke event occurs in that same cycle: it is captured with seq = incremented frame_cnt. The next frame's HDR0 is presented the following cycle with no idle gap, and overrun is not set.
- Stroke event in SEND at any other time:
  - The stroke is dropped and the shadow data is untouched.
  - overrun=1 from the next cycle; it stays set until reset.
- Throughput: with out_ready held at 1, one frame takes 28 cycles. This is far below the sample period.

Test Plan:
- Single frame, checksum: ch1..ch8=24'h000001, out_ready=1, stroke at cycle 10.
  - out_valid rises at cycle 11.
  - Bytes: A5 5A 00, then (00 00 01)x8, then F8.
  - out_valid=0 and busy=0 at cycle 39; frame_cnt=1.
- Backpressure: ch1=24'h123456, out_ready toggling pseudo-randomly.
  - Exactly 28 bytes are accepted, matching the ready=1 sequence (bytes 3..5 = 12 34 56).
  - out_data is stable on every stalled cycle.
- Overrun: new stroke with ch1=24'hFFFFFF while idx=10.
  - The current frame completes with the original data.
  - overrun=1 one cycle after the stroke and stays 1.
  - No second frame is emitted.
- Back-to-back: stroke coincident with acceptance of byte 27 of frame 0.
  - HDR0 of frame 1 appears the next cycle with seq byte = 01.
  - overrun=0.
- Wrap: run 257 frames.
  - Frame 256's seq byte = FF, frame 257's seq byte = 00.
  - frame_cnt reads 01 at the end.
- Reset mid-frame: reset=0 for one cycle at idx=15.
  - out_valid=0, busy=0, frame_cnt=0 the next cycle.
  - A subsequent stroke produces a clean frame with seq=00.
